spi_byte_frontend: RTL and testbench

- Oversampled SPI slave front-end clocked by the local SPI_CLK; sits directly upstream of the address/strobe generator.
- Synchronises the external SCLK/CS_N/MOSI pins and deserialises MOSI into bytes.
- Emits transfer framing pulses, and serialises read-back bytes onto MISO with a per-byte refill request.
- SPI mode 0 (CPOL=0, CPHA=0): sample on SCLK rise, shift on SCLK fall.

---
 rtl/spi_byte_frontend_pkg.sv | 14 +
 rtl/spi_byte_frontend_if.sv | 30 +++
 rtl/spi_pin_sync.sv | 32 +++
 rtl/spi_byte_frontend.sv | 157 +++++++++++++++
 tb/tb_spi_byte_frontend.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_byte_frontend_pkg.sv
// Shared SPI front-end types and constants, reused by the downstream address FSM.
package spi_byte_frontend_pkg;

    localparam int unsigned BYTE_BITS           = 8;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;
    localparam int unsigned BIT_CNT_W           = $clog2(BYTE_BITS);

    typedef enum logic [2:0] {
        SPI_WAIT_IDLE = 3'b001,
        SPI_IDLE      = 3'b010,
        SPI_ACTIVE    = 3'b100
    } spi_state_e;

endpackage

// File: rtl/spi_byte_frontend_if.sv
// SPI pins plus the byte-side handshake of the front-end.
interface spi_byte_frontend_if;

    logic                                        SCLK;
    logic                                        CS_N;
    logic                                        MOSI;
    logic                                        MISO;
    logic                                        MISO_OE;
    logic [spi_byte_frontend_pkg::BYTE_BITS-1:0] tx_data;
    logic                                        start_of_transfer;
    logic                                        end_of_transfer;
    logic [spi_byte_frontend_pkg::BYTE_BITS-1:0] data_in_value;
    logic                                        data_in_ready;
    logic                                        data_out_request;

    // Front-end side
    modport slave (
        input  SCLK, CS_N, MOSI, tx_data,
        output MISO, MISO_OE, start_of_transfer, end_of_transfer,
               data_in_value, data_in_ready, data_out_request
    );

    // Pin driver / byte consumer side
    modport master (
        output SCLK, CS_N, MOSI, tx_data,
        input  MISO, MISO_OE, start_of_transfer, end_of_transfer,
               data_in_value, data_in_ready, data_out_request
    );

endinterface

// File: rtl/spi_pin_sync.sv
// N-stage pin synchroniser with one extra flop for single-cycle edge detection.
module spi_pin_sync #(
    parameter int unsigned STAGES  = 2,
    parameter bit          RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    // Synchroniser chain and edge-detect history flop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], pin};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign level  = chain_q[STAGES-1];
    assign rise_c =  level & ~prev_q;
    assign fall_c = ~level &  prev_q;

endmodule

// File: rtl/spi_byte_frontend.sv
// Oversampled mode-0 SPI slave front-end: pin sync, byte RX, byte TX with refill request.
module spi_byte_frontend
    import spi_byte_frontend_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter bit          LSB_FIRST   = 1'b0
) (
    input  logic               SPI_CLK,
    input  logic               RST_N,
    spi_byte_frontend_if.slave bus
);

    // Cycles after reset before the synchronised CS_N reflects the real pin
    localparam int unsigned SETTLE_MAX = SYNC_STAGES + 1;
    localparam int unsigned SETTLE_W   = $clog2(SETTLE_MAX + 1);

    logic sclk_lvl, sclk_rise_c, sclk_fall_c;
    logic cs_lvl, cs_rise_c, cs_fall_c;
    logic mosi_lvl, mosi_rise_c, mosi_fall_c;
    logic unused_sync;

    spi_byte_frontend_pkg::spi_state_e state_q, state_d;

    logic [SETTLE_W-1:0]  settle_q;
    logic                 settled;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic                 got_bit_q;
    logic [BYTE_BITS-1:0] rx_q, rx_next;
    logic [BYTE_BITS-1:0] tx_q, tx_shifted;
    logic [BYTE_BITS-1:0] data_in_value_q;
    logic                 sot_q, eot_q, req_q, rdy_stage_q, rdy_q, oe_q;
    logic                 sot_d, eot_d, tx_load, tx_shift, rx_shift, byte_done;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(SPI_CLK), .rst_n(RST_N), .pin(bus.SCLK),
        .level(sclk_lvl), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(SPI_CLK), .rst_n(RST_N), .pin(bus.CS_N),
        .level(cs_lvl), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(SPI_CLK), .rst_n(RST_N), .pin(bus.MOSI),
        .level(mosi_lvl), .rise_c(mosi_rise_c), .fall_c(mosi_fall_c)
    );

    // Only edges of SCLK and only the level of MOSI carry meaning here
    assign unused_sync = ^{sclk_lvl, mosi_rise_c, mosi_fall_c};

    assign settled = (settle_q == SETTLE_W'(SETTLE_MAX));

    // Bit-order dependent shift paths
    assign rx_next    = LSB_FIRST ? {mosi_lvl, rx_q[BYTE_BITS-1:1]}
                                  : {rx_q[BYTE_BITS-2:0], mosi_lvl};
    assign tx_shifted = LSB_FIRST ? {1'b0, tx_q[BYTE_BITS-1:1]}
                                  : {tx_q[BYTE_BITS-2:0], 1'b0};

    // FSM state register
    always_ff @(posedge SPI_CLK) begin
        if (!RST_N) begin
            state_q <= SPI_WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; WAIT_IDLE holds off until the synchronised CS_N is known high
    always_comb begin
        state_d = state_q;
        case (state_q)
            SPI_WAIT_IDLE: if (settled && cs_lvl) state_d = SPI_IDLE;
            SPI_IDLE:      if (cs_fall_c)         state_d = SPI_ACTIVE;
            SPI_ACTIVE:    if (cs_rise_c)         state_d = SPI_IDLE;
            default:                              state_d = SPI_WAIT_IDLE;
        endcase
    end

    // Output/control decode; CS edges take priority over SCLK edges
    always_comb begin
        sot_d     = 1'b0;
        eot_d     = 1'b0;
        tx_load   = 1'b0;
        tx_shift  = 1'b0;
        rx_shift  = 1'b0;
        byte_done = 1'b0;
        case (state_q)
            SPI_IDLE: begin
                if (cs_fall_c) begin
                    sot_d   = 1'b1;
                    tx_load = 1'b1;
                end
            end
            SPI_ACTIVE: begin
                if (cs_rise_c) begin
                    eot_d = 1'b1;
                end else if (sclk_rise_c) begin
                    rx_shift  = 1'b1;
                    byte_done = (bit_cnt_q == BIT_CNT_W'(BYTE_BITS - 1));
                end else if (sclk_fall_c) begin
                    if ((bit_cnt_q == '0) && got_bit_q) tx_load  = 1'b1;
                    else                                tx_shift = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered pulse outputs
    always_ff @(posedge SPI_CLK) begin
        if (!RST_N) begin
            settle_q        <= '0;
            bit_cnt_q       <= '0;
            got_bit_q       <= 1'b0;
            rx_q            <= '0;
            tx_q            <= '0;
            data_in_value_q <= '0;
            sot_q           <= 1'b0;
            eot_q           <= 1'b0;
            req_q           <= 1'b0;
            rdy_stage_q     <= 1'b0;
            rdy_q           <= 1'b0;
            oe_q            <= 1'b0;
        end else begin
            if (!settled) settle_q <= settle_q + SETTLE_W'(1);
            sot_q       <= sot_d;
            eot_q       <= eot_d;
            req_q       <= tx_load;
            rdy_stage_q <= byte_done;
            rdy_q       <= rdy_stage_q;
            if (sot_d) begin
                bit_cnt_q <= '0;
                got_bit_q <= 1'b0;
                oe_q      <= 1'b1;
            end
            if (eot_d) oe_q <= 1'b0;
            if (rx_shift) begin
                rx_q      <= rx_next;
                bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                got_bit_q <= 1'b1;
            end
            if (byte_done) data_in_value_q <= rx_next;
            if (tx_load)       tx_q <= bus.tx_data;
            else if (tx_shift) tx_q <= tx_shifted;
        end
    end

    assign bus.MISO              = LSB_FIRST ? tx_q[0] : tx_q[BYTE_BITS-1];
    assign bus.MISO_OE           = oe_q;
    assign bus.start_of_transfer = sot_q;
    assign bus.end_of_transfer   = eot_q;
    assign bus.data_in_value     = data_in_value_q;
    assign bus.data_in_ready     = rdy_q;
    assign bus.data_out_request  = req_q;

endmodule

// File: tb/tb_spi_byte_frontend.sv
// Directed bench: MSB-first instance (dut0) and LSB-first instance (dut1).
module tb_spi_byte_frontend;

    localparam int unsigned HALF = 5;

    logic SPI_CLK = 1'b0;
    logic RST_N;
    always #5 SPI_CLK = ~SPI_CLK;

    spi_byte_frontend_if bus0 ();
    spi_byte_frontend_if bus1 ();

    spi_byte_frontend #(.SYNC_STAGES(2), .LSB_FIRST(1'b0)) dut0 (
        .SPI_CLK(SPI_CLK), .RST_N(RST_N), .bus(bus0)
    );
    spi_byte_frontend #(.SYNC_STAGES(2), .LSB_FIRST(1'b1)) dut1 (
        .SPI_CLK(SPI_CLK), .RST_N(RST_N), .bus(bus1)
    );

    int n_chk = 0;
    int n_fail = 0;
    int tick_cnt = 0;
    int cs_tick, sot_tick, rise_tick, rdy_tick;
    int n_sot [2];
    int n_eot [2];
    int n_rdy [2];
    int n_req [2];
    int n_sep [2];
    logic [7:0] rx_log [2][8];
    logic [7:0] tx_tab [2][8];

    // One SPI_CLK cycle; outputs sampled on the falling edge
    task automatic tick();
        @(negedge SPI_CLK);
        tick_cnt++;
        if (bus0.start_of_transfer) begin n_sot[0]++; sot_tick = tick_cnt; end
        if (bus0.end_of_transfer) n_eot[0]++;
        if (bus0.data_in_ready) begin
            rx_log[0][n_rdy[0] % 8] = bus0.data_in_value;
            n_rdy[0]++;
            rdy_tick = tick_cnt;
            if (bus0.start_of_transfer || bus0.end_of_transfer) n_sep[0]++;
        end
        if (bus0.data_out_request) begin n_req[0]++; bus0.tx_data = tx_tab[0][n_req[0] % 8]; end
        if (bus1.start_of_transfer) n_sot[1]++;
        if (bus1.end_of_transfer) n_eot[1]++;
        if (bus1.data_in_ready) begin
            rx_log[1][n_rdy[1] % 8] = bus1.data_in_value;
            n_rdy[1]++;
            if (bus1.start_of_transfer || bus1.end_of_transfer) n_sep[1]++;
        end
        if (bus1.data_out_request) begin n_req[1]++; bus1.tx_data = tx_tab[1][n_req[1] % 8]; end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            n_sot[i] = 0; n_eot[i] = 0; n_rdy[i] = 0; n_req[i] = 0;
        end
    endtask

    task automatic cs_set(input int inst, input logic v);
        repeat (HALF) tick();
        if (inst == 0) bus0.CS_N = v; else bus1.CS_N = v;
        cs_tick = tick_cnt;
        repeat (2 * HALF) tick();
    endtask

    // One mode-0 bit: MOSI set while SCLK low, MISO read just before the rise
    task automatic spi_bit(input int inst, input logic mosi, output logic miso);
        if (inst == 0) bus0.MOSI = mosi; else bus1.MOSI = mosi;
        repeat (HALF) tick();
        miso = (inst == 0) ? bus0.MISO : bus1.MISO;
        if (inst == 0) bus0.SCLK = 1'b1; else bus1.SCLK = 1'b1;
        rise_tick = tick_cnt;
        repeat (HALF) tick();
        if (inst == 0) bus0.SCLK = 1'b0; else bus1.SCLK = 1'b0;
    endtask

    // Whole byte; miso_seq holds MISO bits in wire order, first bit at the MSB
    task automatic spi_byte(input int inst, input logic [7:0] b, input bit lsb, output logic [7:0] miso_seq);
        logic m;
        miso_seq = '0;
        for (int i = 0; i < 8; i++) begin
            spi_bit(inst, lsb ? b[i] : b[7 - i], m);
            miso_seq = {miso_seq[6:0], m};
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        bus0.SCLK = 1'b0; bus0.CS_N = 1'b1; bus0.MOSI = 1'b0; bus0.tx_data = 8'h00;
        bus1.SCLK = 1'b0; bus1.CS_N = 1'b1; bus1.MOSI = 1'b0; bus1.tx_data = 8'h00;
        repeat (3) tick();
        n_chk++;
        if ({bus0.start_of_transfer, bus0.end_of_transfer, bus0.data_in_ready, bus0.data_out_request} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pulses0: got %b expected 0000",
                {bus0.start_of_transfer, bus0.end_of_transfer, bus0.data_in_ready, bus0.data_out_request});
        end
        n_chk++;
        if ({bus0.MISO, bus0.MISO_OE, bus0.data_in_value} !== 10'h000) begin
            n_fail++; $display("FAIL reset_data0: got %h expected 000", {bus0.MISO, bus0.MISO_OE, bus0.data_in_value});
        end
        n_chk++;
        if ({bus1.start_of_transfer, bus1.end_of_transfer, bus1.data_in_ready, bus1.data_out_request,
             bus1.MISO, bus1.MISO_OE, bus1.data_in_value} !== 14'h0) begin
            n_fail++; $display("FAIL reset_all1: got %h expected 0", {bus1.start_of_transfer, bus1.end_of_transfer,
                bus1.data_in_ready, bus1.data_out_request, bus1.MISO, bus1.MISO_OE, bus1.data_in_value});
        end
        RST_N = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_rx_two_bytes();
        logic [7:0] mseq;
        for (int i = 0; i < 8; i++) tx_tab[0][i] = 8'h00;
        bus0.tx_data = 8'h00;
        clear_counts();
        cs_set(0, 1'b0);
        n_chk++;
        if (sot_tick - cs_tick !== 3) begin n_fail++; $display("FAIL sot_latency: got %0d expected 3", sot_tick - cs_tick); end
        n_chk++;
        if (bus0.MISO_OE !== 1'b1) begin n_fail++; $display("FAIL oe_active: got %b expected 1", bus0.MISO_OE); end
        spi_byte(0, 8'h81, 1'b0, mseq);
        n_chk++;
        if (rdy_tick - rise_tick !== 4) begin n_fail++; $display("FAIL rdy_latency: got %0d expected 4", rdy_tick - rise_tick); end
        spi_byte(0, 8'h23, 1'b0, mseq);
        cs_set(0, 1'b1);
        n_chk++;
        if (n_sot[0] !== 1) begin n_fail++; $display("FAIL rx_sot_count: got %0d expected 1", n_sot[0]); end
        n_chk++;
        if (n_rdy[0] !== 2) begin n_fail++; $display("FAIL rx_rdy_count: got %0d expected 2", n_rdy[0]); end
        n_chk++;
        if (rx_log[0][0] !== 8'h81) begin n_fail++; $display("FAIL rx_byte0: got %h expected 81", rx_log[0][0]); end
        n_chk++;
        if (rx_log[0][1] !== 8'h23) begin n_fail++; $display("FAIL rx_byte1: got %h expected 23", rx_log[0][1]); end
        n_chk++;
        if (n_eot[0] !== 1) begin n_fail++; $display("FAIL rx_eot_count: got %0d expected 1", n_eot[0]); end
        n_chk++;
        if (bus0.MISO_OE !== 1'b0) begin n_fail++; $display("FAIL oe_idle: got %b expected 0", bus0.MISO_OE); end
    endtask

    task automatic test_read_path();
        logic [7:0] m0, m1, m2;
        tx_tab[0][0] = 8'hA5; tx_tab[0][1] = 8'h3C; tx_tab[0][2] = 8'hFF; tx_tab[0][3] = 8'h00;
        bus0.tx_data = 8'hA5;
        clear_counts();
        cs_set(0, 1'b0);
        spi_byte(0, 8'h00, 1'b0, m0);
        spi_byte(0, 8'h00, 1'b0, m1);
        spi_byte(0, 8'h00, 1'b0, m2);
        cs_set(0, 1'b1);
        n_chk++;
        if (m0 !== 8'hA5) begin n_fail++; $display("FAIL miso_byte0: got %h expected a5", m0); end
        n_chk++;
        if (m1 !== 8'h3C) begin n_fail++; $display("FAIL miso_byte1: got %h expected 3c", m1); end
        n_chk++;
        if (m2 !== 8'hFF) begin n_fail++; $display("FAIL miso_byte2: got %h expected ff", m2); end
        n_chk++;
        if (n_req[0] !== 4) begin n_fail++; $display("FAIL req_count: got %0d expected 4", n_req[0]); end
        n_chk++;
        if (n_rdy[0] !== 3) begin n_fail++; $display("FAIL read_rdy_count: got %0d expected 3", n_rdy[0]); end
    endtask

    task automatic test_partial_byte();
        logic [7:0] mseq;
        logic m;
        clear_counts();
        cs_set(0, 1'b0);
        spi_byte(0, 8'hC3, 1'b0, mseq);
        for (int i = 0; i < 5; i++) spi_bit(0, 1'b1, m);
        cs_set(0, 1'b1);
        n_chk++;
        if (n_rdy[0] !== 1) begin n_fail++; $display("FAIL partial_rdy_count: got %0d expected 1", n_rdy[0]); end
        n_chk++;
        if (rx_log[0][0] !== 8'hC3) begin n_fail++; $display("FAIL partial_byte0: got %h expected c3", rx_log[0][0]); end
        n_chk++;
        if (n_eot[0] !== 1) begin n_fail++; $display("FAIL partial_eot: got %0d expected 1", n_eot[0]); end
        cs_set(0, 1'b0);
        spi_byte(0, 8'h96, 1'b0, mseq);
        cs_set(0, 1'b1);
        n_chk++;
        if (n_rdy[0] !== 2 || rx_log[0][1] !== 8'h96) begin
            n_fail++; $display("FAIL partial_next: got count %0d byte %h expected count 2 byte 96", n_rdy[0], rx_log[0][1]);
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic [7:0] mseq;
        logic m;
        clear_counts();
        cs_set(0, 1'b0);
        for (int i = 0; i < 4; i++) spi_bit(0, i[0], m);
        RST_N = 1'b0;
        repeat (3) tick();
        RST_N = 1'b1;
        clear_counts();
        repeat (10) tick();
        for (int i = 0; i < 4; i++) spi_bit(0, 1'b1, m);
        repeat (10) tick();
        n_chk++;
        if (n_sot[0] !== 0) begin n_fail++; $display("FAIL rst_false_start: got %0d expected 0", n_sot[0]); end
        n_chk++;
        if (n_rdy[0] !== 0) begin n_fail++; $display("FAIL rst_partial_rdy: got %0d expected 0", n_rdy[0]); end
        cs_set(0, 1'b1);
        n_chk++;
        if (n_eot[0] !== 0) begin n_fail++; $display("FAIL rst_eot: got %0d expected 0", n_eot[0]); end
        cs_set(0, 1'b0);
        spi_byte(0, 8'h5A, 1'b0, mseq);
        cs_set(0, 1'b1);
        n_chk++;
        if (n_sot[0] !== 1) begin n_fail++; $display("FAIL rst_restart_sot: got %0d expected 1", n_sot[0]); end
        n_chk++;
        if (n_rdy[0] !== 1 || rx_log[0][0] !== 8'h5A) begin
            n_fail++; $display("FAIL rst_byte: got count %0d byte %h expected count 1 byte 5a", n_rdy[0], rx_log[0][0]);
        end
    endtask

    task automatic test_cs_rise_on_last_edge();
        logic m;
        clear_counts();
        cs_set(0, 1'b0);
        for (int i = 0; i < 7; i++) spi_bit(0, 1'b1, m);
        bus0.MOSI = 1'b1;
        repeat (HALF) tick();
        bus0.SCLK = 1'b1;
        bus0.CS_N = 1'b1;
        repeat (HALF) tick();
        bus0.SCLK = 1'b0;
        repeat (2 * HALF) tick();
        n_chk++;
        if (n_rdy[0] !== 0) begin n_fail++; $display("FAIL coincide_rdy: got %0d expected 0", n_rdy[0]); end
        n_chk++;
        if (n_eot[0] !== 1) begin n_fail++; $display("FAIL coincide_eot: got %0d expected 1", n_eot[0]); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] mseq;
        for (int i = 0; i < 8; i++) tx_tab[1][i] = 8'h00;
        tx_tab[1][0] = 8'h80;
        bus1.tx_data = 8'h80;
        clear_counts();
        cs_set(1, 1'b0);
        spi_byte(1, 8'h01, 1'b1, mseq);
        cs_set(1, 1'b1);
        n_chk++;
        if (mseq !== 8'h01) begin n_fail++; $display("FAIL lsb_miso_seq: got %b expected 00000001", mseq); end
        n_chk++;
        if (n_rdy[1] !== 1 || rx_log[1][0] !== 8'h01) begin
            n_fail++; $display("FAIL lsb_rx: got count %0d byte %h expected count 1 byte 01", n_rdy[1], rx_log[1][0]);
        end
        n_chk++;
        if (n_sot[1] !== 1 || n_eot[1] !== 1) begin
            n_fail++; $display("FAIL lsb_framing: got sot %0d eot %0d expected 1 1", n_sot[1], n_eot[1]);
        end
    endtask

    task automatic test_pulse_separation();
        n_chk++;
        if (n_sep[0] !== 0) begin n_fail++; $display("FAIL separation0: got %0d expected 0", n_sep[0]); end
        n_chk++;
        if (n_sep[1] !== 0) begin n_fail++; $display("FAIL separation1: got %0d expected 0", n_sep[1]); end
    endtask

    initial begin
        n_sep[0] = 0;
        n_sep[1] = 0;
        clear_counts();
        test_reset();
        test_rx_two_bytes();
        test_read_path();
        test_partial_byte();
        test_reset_mid_transfer();
        test_cs_rise_on_last_edge();
        test_lsb_first();
        test_pulse_separation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
